// File: rtl/alu_pkg.sv
// Shared opcode and result-stage encodings for the shared bitwise ALU.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise evaluator: res = a <op> b.
module logic_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        res = '0;
        unique case (op)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOR: res = ~(a | b);
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Two requesters share one bitwise ALU through a round-robin arbiter and a
// single full-throughput result register with saturating grant counters.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_res,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_next;
    logic             last_gnt;
    logic             can_accept;
    logic             grant;
    logic [WIDTH-1:0] alu_res;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    // Next-state logic: a grant always fills; an unconsumed result stays.
    always_comb begin
        state_next = EMPTY;
        if (grant || (state == FULL && !rsp_ready)) state_next = FULL;
    end

    // last_gnt holds the most recent grant; the other requester wins a tie.
    always_comb begin
        can_accept = (state == EMPTY) || rsp_ready;
        req0_ready = can_accept && req0_valid && (!req1_valid || last_gnt);
        req1_ready = can_accept && req1_valid && (!req0_valid || !last_gnt);
        grant      = req0_ready || req1_ready;
        rsp_valid  = (state == FULL);
    end

    logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
        .op  (req1_ready ? op_t'(req1_op) : op_t'(req0_op)),
        .a   (req1_ready ? req1_a : req0_a),
        .b   (req1_ready ? req1_b : req0_b),
        .res (alu_res)
    );

    // Reset leaves last_gnt at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            last_gnt <= 1'b1;
            rsp_id   <= 1'b0;
            rsp_res  <= '0;
        end else if (grant) begin
            last_gnt <= req1_ready;
            rsp_id   <= req1_ready;
            rsp_res  <= alu_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (req0_ready && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + CNT_ONE;
            if (req1_ready && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + CNT_ONE;
        end
    end

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter WIDTH, default 32, operand and result bit width.
REQ-002 Parameter CNT_W, default 16, width of each per-requester grant counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0_valid  input  1  requester 0 presents an operation.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle (valid & ready).
REQ-007 req0_op  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-008 req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-009 req1_valid, req1_ready, req1_op, req1_a, req1_b  same widths and meaning as REQ-005..008, for requester 1.
REQ-010 rsp_valid  output  1  result register holds a valid result.
REQ-011 rsp_ready  input  1  consumer takes result this cycle (rsp_valid & rsp_ready).
REQ-012 rsp_id  output  1  index of the requester that issued the result.
REQ-013 rsp_res  output  WIDTH  bitwise result.
REQ-014 gnt_cnt0, gnt_cnt1  output  CNT_W  saturating count of accepted operations per requester.

Function
REQ-015 Output stage SHALL be a single result register with states EMPTY and FULL; rsp_valid SHALL be 1 exactly in FULL.
REQ-016 Stage SHALL be able to accept a new operation when EMPTY, or when FULL with rsp_ready=1 in the same cycle (full-throughput, no bubble).
REQ-017 When able to accept and exactly one reqN_valid=1, that requester SHALL be granted (reqN_ready=1).
REQ-018 When able to accept and both valid, grant SHALL go to the requester not granted most recently (round-robin); after reset the priority pointer SHALL favour requester 0.
REQ-019 At most one reqN_ready SHALL be 1 per cycle; reqN_ready SHALL be 0 whenever reqN_valid=0 or the stage cannot accept.
REQ-020 reqN_ready SHALL be combinational from valids, pointer, state and rsp_ready; no combinational path from operand/opcode inputs to any ready.
REQ-021 On grant, the result of the opcode on the granted operands SHALL be captured into rsp_res, with rsp_id = granted index, visible the next cycle (latency 1).
REQ-022 FULL with rsp_ready=0 SHALL hold rsp_res, rsp_id, rsp_valid stable; both readies 0.
REQ-023 FULL with rsp_ready=1 and no grant SHALL transition to EMPTY; with a grant SHALL stay FULL with new contents.
REQ-024 Priority pointer SHALL update only on a grant, to the granted index.
REQ-025 gnt_cntN SHALL increment on each requester-N grant and saturate at all ones (no wrap).
REQ-026 Requester holding valid while not granted SHALL not be dropped; a requester continuously valid against a competitor SHALL be granted within 2 accepting cycles.

Reset
REQ-027 rst_n low SHALL immediately force: state EMPTY, rsp_valid 0, rsp_id 0, rsp_res 0, pointer favouring requester 0, gnt_cnt0/1 0.
REQ-028 Reset asserted mid-operation SHALL discard any held result without producing a response; first grant after release follows REQ-017/018.

Structure
REQ-029 Opcode encodings (OP_AND, OP_OR, OP_XOR, OP_NOR) and the EMPTY/FULL state encoding SHALL live in shared package alu_pkg.
REQ-030 Bitwise evaluation SHALL be a combinational sub-module logic_unit (inputs op, a, b; output res); arbitration, state and counters stay in alu_share_arb.

Verification
REQ-031 Reset, req0 valid op=01 a=0x0000_00F0 b=0x0000_000F, rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_res=0x0000_00FF; gnt_cnt0=1.
REQ-032 Both valid every cycle, rsp_ready=1, 6 cycles -> grants alternate 0,1,0,1,0,1; one response per cycle; gnt_cnt0=gnt_cnt1=3.
REQ-033 rsp_ready=0 with FULL, both requesters valid for 4 cycles -> both readies 0, rsp_res/rsp_id unchanged; on rsp_ready=1 exactly one grant same cycle.
REQ-034 All opcodes with a=0xFFFF_0000 b=0xFF00_FF00 -> AND 0xFF00_0000, OR 0xFFFF_FF00, XOR 0x00FF_FF00, NOR 0x0000_00FF.
REQ-035 CNT_W=4, 20 consecutive req1 grants -> gnt_cnt1 stops at 0xF.
REQ-036 rst_n pulsed low while FULL -> rsp_valid falls asynchronously, no response emitted, counters 0, next simultaneous request granted to requester 0.
